// File: rtl/bus_reg_pkg.sv
// ---------------------------------------------------------------------------
// bus_reg_pkg
// Shared definitions for the lightweight-bridge register slave:
//   - state_t       : transaction sequencer states
//   - ADDR_*        : word offsets (byte address [9:2]) of the fixed registers
//   - CTRL_BASE     : first control word, STS_BASE : first status word
//   - merge_bytes() : lane-wise merge of a write into an existing word
// ---------------------------------------------------------------------------
package bus_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [7:0] ADDR_ID         = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH    = 8'h01;
    localparam logic [7:0] ADDR_IRQ_STATUS = 8'h02;
    localparam logic [7:0] ADDR_IRQ_ENABLE = 8'h03;
    localparam logic [7:0] CTRL_BASE       = 8'h08;
    localparam logic [7:0] STS_BASE        = 8'h40;

    // Byte lanes with be[b]=1 take the new data, the rest keep the old word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] result;
        for (int b = 0; b < 4; b++) begin
            result[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/irq_latch.sv
// ---------------------------------------------------------------------------
// irq_latch
// Edge-latched interrupt status with write-1-to-clear and an enable mask.
//   clk, reset   : clock, synchronous active-high reset
//   src          : interrupt sources, a rising edge sets the status bit
//   clr_valid    : apply clr_mask this cycle (W1C write to IRQ_STATUS)
//   clr_mask     : bits to clear
//   en_wr        : load enable with en_data this cycle
//   en_data      : new enable mask (already lane-merged by the caller)
//   status       : latched status bits
//   enable       : enable mask
//   irq          : registered |(status & enable)
// ---------------------------------------------------------------------------
module irq_latch #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] src,
    input  logic               clr_valid,
    input  logic [NUM_IRQ-1:0] clr_mask,
    input  logic               en_wr,
    input  logic [NUM_IRQ-1:0] en_data,
    output logic [NUM_IRQ-1:0] status,
    output logic [NUM_IRQ-1:0] enable,
    output logic               irq
);

    logic [NUM_IRQ-1:0] src_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;

    assign rise = src & ~src_q;
    assign clr  = clr_valid ? clr_mask : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q  <= '0;
            status <= '0;
            enable <= '0;
            irq    <= 1'b0;
        end else begin
            src_q  <= src;
            // The set term is OR-ed after the clear so a new edge wins
            // over a simultaneous W1C on the same bit.
            status <= (status & ~clr) | rise;
            if (en_wr) begin
                enable <= en_data;
            end
            irq    <= |(status & enable);
        end
    end

endmodule

// File: rtl/bus_reg_ctrl.sv
// ---------------------------------------------------------------------------
// bus_reg_ctrl
// Fabric-side slave for the HPS lightweight bridge conduits. Each bridge
// transaction is captured, waited out for ACK_DELAY cycles, completed with a
// one-cycle acknowledge, and followed by one dead cycle.
//
// Ports:
//   clk, reset       : clock, synchronous active-high reset
//   bus_address      : byte address, word index is [9:2]
//   bus_enable       : request, held by the master until acknowledged
//   bus_byte_enable  : write lane enables
//   bus_rw           : 1 = read, 0 = write
//   bus_write_data   : write data
//   bus_read_data    : read data, valid with acknowledge and held after it
//   bus_acknowledge  : one-cycle completion
//   bus_irq          : level interrupt
//   ctrl_regs        : control words, word 0 at the LSBs
//   ctrl_wr_strobe   : one-cycle pulse per written control word
//   sts_regs         : status words from the fabric
//   irq_src          : rising-edge interrupt sources
//   fsm_state        : current sequencer state (observation only)
//
// Handshake: the master raises bus_enable with address/rw/data/lanes stable.
// The request is captured on the first IDLE cycle that sees bus_enable=1;
// after that bus_enable is not looked at until the sequencer returns to IDLE,
// so dropping it early does not abort anything. bus_acknowledge is high for
// exactly one cycle (ACK) and the following HOLD cycle ignores bus_enable so
// the master has time to drop it.
// ---------------------------------------------------------------------------
module bus_reg_ctrl
    import bus_reg_pkg::*;
#(
    parameter int          NUM_CTRL  = 8,
    parameter int          NUM_STS   = 8,
    parameter int          NUM_IRQ   = 8,
    parameter int          ACK_DELAY = 1,
    parameter logic [31:0] ID_VALUE  = 32'h534B5931
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [9:0]              bus_address,
    input  logic                    bus_enable,
    input  logic [3:0]              bus_byte_enable,
    input  logic                    bus_rw,
    input  logic [31:0]             bus_write_data,
    output logic [31:0]             bus_read_data,
    output logic                    bus_acknowledge,
    output logic                    bus_irq,
    output logic [32*NUM_CTRL-1:0]  ctrl_regs,
    output logic [NUM_CTRL-1:0]     ctrl_wr_strobe,
    input  logic [32*NUM_STS-1:0]   sts_regs,
    input  logic [NUM_IRQ-1:0]      irq_src,
    output state_t                  fsm_state
);

    // ---------------------------------------------------------------
    // Parameter range checks
    // ---------------------------------------------------------------
    if (NUM_CTRL < 1 || NUM_CTRL > 56) begin : g_bad_num_ctrl
        $error("bus_reg_ctrl: NUM_CTRL must be 1..56");
    end
    if (NUM_STS < 1 || NUM_STS > 56) begin : g_bad_num_sts
        $error("bus_reg_ctrl: NUM_STS must be 1..56");
    end
    if (NUM_IRQ < 1 || NUM_IRQ > 32) begin : g_bad_num_irq
        $error("bus_reg_ctrl: NUM_IRQ must be 1..32");
    end
    if (ACK_DELAY < 0 || ACK_DELAY > 7) begin : g_bad_ack_delay
        $error("bus_reg_ctrl: ACK_DELAY must be 0..7");
    end

    localparam logic [2:0] ACK_CNT = 3'(ACK_DELAY);

    // ---------------------------------------------------------------
    // Sequencer
    // ---------------------------------------------------------------
    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    // Captured request
    logic [7:0]  word_q;
    logic        rw_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;

    // The two address LSBs select a byte within a word and carry no meaning.
    logic        unused_addr_lsbs;
    assign unused_addr_lsbs = &{1'b0, bus_address[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            word_q  <= '0;
            rw_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == ST_IDLE && bus_enable) begin
                word_q  <= bus_address[9:2];
                rw_q    <= bus_rw;
                be_q    <= bus_byte_enable;
                wdata_q <= bus_write_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus_enable) begin
                    state_nxt = ST_WAIT;
                    cnt_nxt   = ACK_CNT;
                end
            end
            ST_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt = ST_ACK;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            ST_ACK:  state_nxt = ST_HOLD;
            ST_HOLD: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign fsm_state       = state;
    assign bus_acknowledge = (state == ST_ACK);

    logic wr_commit;
    logic rd_commit;
    assign wr_commit = (state == ST_ACK) && !rw_q;
    assign rd_commit = (state == ST_ACK) &&  rw_q;

    // ---------------------------------------------------------------
    // Register bank
    // ---------------------------------------------------------------
    logic [31:0]        ctrl_q [NUM_CTRL];
    logic [31:0]        scratch_q;
    logic [NUM_IRQ-1:0] irq_status;
    logic [NUM_IRQ-1:0] irq_enable;

    always_ff @(posedge clk) begin
        if (reset) begin
            scratch_q <= '0;
            for (int i = 0; i < NUM_CTRL; i++) begin
                ctrl_q[i] <= '0;
            end
        end else if (wr_commit) begin
            if (word_q == ADDR_SCRATCH) begin
                scratch_q <= merge_bytes(scratch_q, wdata_q, be_q);
            end
            for (int i = 0; i < NUM_CTRL; i++) begin
                if (word_q == 8'(CTRL_BASE + i)) begin
                    ctrl_q[i] <= merge_bytes(ctrl_q[i], wdata_q, be_q);
                end
            end
        end
    end

    always_comb begin
        ctrl_regs      = '0;
        ctrl_wr_strobe = '0;
        for (int i = 0; i < NUM_CTRL; i++) begin
            ctrl_regs[32*i +: 32] = ctrl_q[i];
            // Strobe fires on any write to the word, lanes notwithstanding.
            ctrl_wr_strobe[i]     = wr_commit && (word_q == 8'(CTRL_BASE + i));
        end
    end

    // ---------------------------------------------------------------
    // Interrupts
    // ---------------------------------------------------------------
    logic               irq_clr_valid;
    logic               irq_en_wr;
    logic [NUM_IRQ-1:0] irq_clr_mask;
    logic [NUM_IRQ-1:0] irq_en_data;

    assign irq_clr_valid = wr_commit && (word_q == ADDR_IRQ_STATUS);
    assign irq_en_wr     = wr_commit && (word_q == ADDR_IRQ_ENABLE);

    always_comb begin
        irq_clr_mask = '0;
        irq_en_data  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            irq_clr_mask[i] = wdata_q[i] & be_q[i/8];
            irq_en_data[i]  = be_q[i/8] ? wdata_q[i] : irq_enable[i];
        end
    end

    irq_latch #(
        .NUM_IRQ (NUM_IRQ)
    ) u_irq_latch (
        .clk       (clk),
        .reset     (reset),
        .src       (irq_src),
        .clr_valid (irq_clr_valid),
        .clr_mask  (irq_clr_mask),
        .en_wr     (irq_en_wr),
        .en_data   (irq_en_data),
        .status    (irq_status),
        .enable    (irq_enable),
        .irq       (bus_irq)
    );

    // ---------------------------------------------------------------
    // Read path: live mux during ACK (so status is sampled that cycle),
    // then the registered copy is shown until the next read ACK.
    // ---------------------------------------------------------------
    logic [31:0] rd_mux;
    logic [31:0] rd_hold;

    always_comb begin
        rd_mux = '0;
        if (word_q == ADDR_ID) begin
            rd_mux = ID_VALUE;
        end else if (word_q == ADDR_SCRATCH) begin
            rd_mux = scratch_q;
        end else if (word_q == ADDR_IRQ_STATUS) begin
            rd_mux[NUM_IRQ-1:0] = irq_status;
        end else if (word_q == ADDR_IRQ_ENABLE) begin
            rd_mux[NUM_IRQ-1:0] = irq_enable;
        end
        for (int i = 0; i < NUM_CTRL; i++) begin
            if (word_q == 8'(CTRL_BASE + i)) begin
                rd_mux = ctrl_q[i];
            end
        end
        for (int i = 0; i < NUM_STS; i++) begin
            if (word_q == 8'(STS_BASE + i)) begin
                rd_mux = sts_regs[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_hold <= '0;
        end else if (rd_commit) begin
            rd_hold <= rd_mux;
        end
    end

    assign bus_read_data = rd_commit ? rd_mux : rd_hold;

endmodule
